// File: rtl/mlc_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mlc_pattern_pkg
//  Description : Shared types and constants for the MLC pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mlc_pattern_pkg;

   // Pattern selection, encoded exactly as the mode input port
   typedef enum logic [1:0] {
      CHECKER     = 2'd0,
      CHECKER_INV = 2'd1,
      RAMP        = 2'd2,
      RANDOM      = 2'd3
   } pg_mode_e;

   // Sequencer state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pg_state_e;

   // Galois tap mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] C_LFSR_POLY = 32'h8020_0003;

endpackage : mlc_pattern_pkg
`default_nettype wire

// File: rtl/mlc_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : mlc_lfsr32
//  Description : 32-bit Galois LFSR with synchronous seed load and step.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlc_lfsr32
   import mlc_pattern_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   output logic [31:0] state
);

   logic [31:0] r_state;
   logic [31:0] w_state_nxt;

   // One Galois shift: feed the outgoing bit back through the tap mask
   always_comb begin
      w_state_nxt = {1'b0, r_state[31:1]} ^ (r_state[0] ? C_LFSR_POLY : 32'd0);
   end

   // State register; load wins over step so a restart always begins at SEED
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SEED;
      end else if (load) begin
         r_state <= SEED;
      end else if (step) begin
         r_state <= w_state_nxt;
      end
   end

   assign state = r_state;

endmodule : mlc_lfsr32
`default_nettype wire

// File: rtl/mlc_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mlc_pattern_gen
//  Description : Multi-level-cell data pattern generator. Streams words of
//                WORD_WIDTH cells (checkerboard, inverse checkerboard, level
//                ramp or pseudo-random) over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlc_pattern_gen
   import mlc_pattern_pkg::*;
#(
   parameter int          WORD_WIDTH = 48,
   parameter int          BPC_MAX    = 3,
   parameter int          ADDR_WIDTH = 16,
   parameter logic [31:0] SEED       = 32'hACE1_2024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [1:0]                    mode,
   input  logic [BPC_MAX:0]              num_levels,
   input  logic [ADDR_WIDTH-1:0]         num_words,
   input  logic                          data_ready,
   output logic                          data_valid,
   output logic [WORD_WIDTH*BPC_MAX-1:0] data_out,
   output logic [ADDR_WIDTH-1:0]         addr_out,
   output logic                          done,
   output logic                          cfg_err
);

   localparam int unsigned C_MAX_LEVELS = 32'd1 << BPC_MAX;

   pg_state_e                     r_state;
   pg_state_e                     w_state_nxt;
   pg_mode_e                      r_mode;
   logic [BPC_MAX:0]              r_levels;
   logic [BPC_MAX-1:0]            r_mask;
   logic [BPC_MAX-1:0]            r_ramp;
   logic [ADDR_WIDTH-1:0]         r_addr;
   logic [ADDR_WIDTH-1:0]         r_last;
   logic                          r_cfg_err;
   logic [31:0]                   w_lfsr;
   logic [BPC_MAX-1:0]            w_lm1;
   logic [BPC_MAX-1:0]            w_mask_new;
   logic                          w_lvl_legal;
   logic                          w_start;
   logic                          w_beat;
   logic [WORD_WIDTH*BPC_MAX-1:0] w_cells;

   assign w_lvl_legal = (32'(num_levels) >= 32'd2) && (32'(num_levels) <= C_MAX_LEVELS);
   assign w_start     = (r_state == IDLE) && enable && w_lvl_legal;
   assign w_beat      = (r_state == RUN) && data_ready;
   // Modulo-2**BPC_MAX subtraction also gives the right top level when L = 2**BPC_MAX
   assign w_lm1       = r_levels[BPC_MAX-1:0] - 1'b1;

   // Mask of clog2(L) low bits, derived from the requested level count at start
   always_comb begin
      w_mask_new    = '0;
      w_mask_new[0] = 1'b1;
      for (int b = 1; b < BPC_MAX; b++) begin
         if ((32'd1 << b) < 32'(num_levels)) begin
            w_mask_new[b] = 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; dropping enable aborts a run or releases DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end else if (w_beat && (r_addr == r_last)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs; the word is only presented while RUN
   always_comb begin
      data_valid = (r_state == RUN);
      done       = (r_state == DONE);
      data_out   = (r_state == RUN) ? w_cells : '0;
   end

   // Config latch, address/ramp counters and sticky configuration error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode    <= CHECKER;
         r_levels  <= '0;
         r_mask    <= '0;
         r_ramp    <= '0;
         r_addr    <= '0;
         r_last    <= '0;
         r_cfg_err <= 1'b0;
      end else if (w_start) begin
         r_mode    <= pg_mode_e'(mode);
         r_levels  <= num_levels;
         r_mask    <= w_mask_new;
         r_ramp    <= '0;
         r_addr    <= '0;
         r_last    <= (num_words == '0) ? '0 : num_words - 1'b1;
         r_cfg_err <= 1'b0;
      end else begin
         if ((r_state == IDLE) && enable) begin
            r_cfg_err <= 1'b1;
         end
         if (w_beat) begin
            r_addr <= r_addr + 1'b1;
            r_ramp <= (r_ramp == w_lm1) ? '0 : r_ramp + 1'b1;
         end
      end
   end

   assign addr_out = r_addr;
   assign cfg_err  = r_cfg_err;

   mlc_lfsr32 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (w_start),
      .step  (w_beat),
      .state (w_lfsr)
   );

   // Per-cell level mux
   for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_cell
      localparam logic C_ODD = 1'((gi % 2) == 1);

      logic [BPC_MAX-1:0] w_raw;
      logic [BPC_MAX-1:0] w_msk;
      logic [BPC_MAX-1:0] w_rnd;
      logic [BPC_MAX-1:0] w_lvl;
      logic               w_par;

      for (genvar gj = 0; gj < BPC_MAX; gj++) begin : g_bit
         assign w_raw[gj] = w_lfsr[(gi*BPC_MAX + gj) % 32];
      end

      assign w_msk = w_raw & r_mask;
      // Masked value is below 2L, so a single conditional subtract folds it into 0..L-1
      assign w_rnd = ({1'b0, w_msk} >= r_levels) ? (w_msk - r_levels[BPC_MAX-1:0]) : w_msk;
      assign w_par = r_addr[0] ^ C_ODD;

      // Select the level for this cell from the latched mode
      always_comb begin
         w_lvl = '0;
         case (r_mode)
            CHECKER:     w_lvl = w_par ? w_lm1 : '0;
            CHECKER_INV: w_lvl = w_par ? '0 : w_lm1;
            RAMP:        w_lvl = r_ramp;
            default:     w_lvl = w_rnd;
         endcase
      end

      assign w_cells[gi*BPC_MAX +: BPC_MAX] = w_lvl;
   end

endmodule : mlc_pattern_gen
`default_nettype wire
